// File: rtl/reset_sequencer.sv
// Board-level reset controller. It debounces the push-button and holds every domain in reset,
// then releases the domains one at a time in index order.
module reset_sequencer #(
  parameter int HOLD_CYCLES     = 50_000,
  parameter int STAGE_CYCLES    = 16,
  parameter int NUM_DOMAINS     = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic                   SYS_CLK,
  input  logic                   reset,
  input  logic                   btn_n,
  input  logic                   sw_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   done,
  output logic                   busy,
  output logic [7:0]             reset_count
);

  localparam int MAX_HS  = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int MAX_CYC = (MAX_HS > DEBOUNCE_CYCLES) ? MAX_HS : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam int IW      = $clog2(NUM_DOMAINS) + 1;

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] FIRST_MASK = NUM_DOMAINS'(1);

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_STAGE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  logic                   btn_meta_r;
  logic                   btn_sync_r;
  logic                   btn_level_s;
  logic [CW-1:0]          db_cnt_r;
  logic [CW-1:0]          db_cnt_next_s;
  logic                   pressed_r;
  logic                   pressed_next_s;
  logic                   req_s;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_next_s;
  logic [IW-1:0]          idx_r;
  logic [IW-1:0]          idx_next_s;
  logic [NUM_DOMAINS-1:0] rst_out_r;
  logic [NUM_DOMAINS-1:0] rst_next_s;
  logic [NUM_DOMAINS-1:0] stage_mask_s;
  logic [7:0]             reset_count_r;
  logic [7:0]             count_next_s;
  logic                   done_r;
  logic                   busy_r;

  // Two-flop synchroniser for the raw button, idling at the released level
  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      btn_meta_r <= 1'b1;
      btn_sync_r <= 1'b1;
    end else begin
      btn_meta_r <= btn_n;
      btn_sync_r <= btn_meta_r;
    end
  end

  assign btn_level_s = ~btn_sync_r;

  // Debounce: accept a new level only after an unbroken run of mismatching samples
  always_comb begin
    db_cnt_next_s  = '0;
    pressed_next_s = pressed_r;
    if (btn_level_s != pressed_r) begin
      if (db_cnt_r == DB_LAST) begin
        pressed_next_s = ~pressed_r;
        db_cnt_next_s  = '0;
      end else begin
        db_cnt_next_s  = db_cnt_r + CNT_ONE;
      end
    end else begin
      db_cnt_next_s = '0;
    end
  end

  // Debounce state registers
  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      db_cnt_r  <= '0;
      pressed_r <= 1'b0;
    end else begin
      db_cnt_r  <= db_cnt_next_s;
      pressed_r <= pressed_next_s;
    end
  end

  assign req_s = pressed_r | sw_req;

  // One-hot mask selecting the domain due for release in STAGE
  always_comb begin
    stage_mask_s = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      stage_mask_s[i] = (idx_r == IW'(i));
    end
  end

  // Sequencer next-state: a request always wins over a terminal count
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    idx_next_s   = idx_r;
    rst_next_s   = rst_out_r;
    count_next_s = reset_count_r;
    case (state_r)
      ST_HOLD: begin
        rst_next_s = '1;
        if (req_s) begin
          cnt_next_s = '0;
        end else if (cnt_r == HOLD_LAST) begin
          cnt_next_s = '0;
          idx_next_s = IDX_ONE;
          rst_next_s = ~FIRST_MASK;
          if (NUM_DOMAINS == 1) begin
            state_next_s = ST_RUN;
          end else begin
            state_next_s = ST_STAGE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_STAGE: begin
        if (req_s) begin
          state_next_s = ST_HOLD;
          cnt_next_s   = '0;
          idx_next_s   = '0;
          rst_next_s   = '1;
          count_next_s = (reset_count_r == 8'd255) ? reset_count_r : reset_count_r + 8'd1;
        end else if (cnt_r == STAGE_LAST) begin
          cnt_next_s = '0;
          rst_next_s = rst_out_r & ~stage_mask_s;
          if (idx_r == IDX_LAST) begin
            state_next_s = ST_RUN;
          end else begin
            idx_next_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (req_s) begin
          state_next_s = ST_HOLD;
          cnt_next_s   = '0;
          idx_next_s   = '0;
          rst_next_s   = '1;
          count_next_s = (reset_count_r == 8'd255) ? reset_count_r : reset_count_r + 8'd1;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      default: begin
        state_next_s = ST_HOLD;
        cnt_next_s   = '0;
        idx_next_s   = '0;
        rst_next_s   = '1;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge SYS_CLK or posedge reset) begin
    if (reset) begin
      state_r       <= ST_HOLD;
      cnt_r         <= '0;
      idx_r         <= '0;
      rst_out_r     <= '1;
      reset_count_r <= 8'd0;
      done_r        <= 1'b0;
      busy_r        <= 1'b1;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      idx_r         <= idx_next_s;
      rst_out_r     <= rst_next_s;
      reset_count_r <= count_next_s;
      done_r        <= (state_next_s == ST_RUN);
      busy_r        <= (state_next_s != ST_RUN);
    end
  end

  assign rst_out     = rst_out_r;
  assign done        = done_r;
  assign busy        = busy_r;
  assign reset_count = reset_count_r;

endmodule
